// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx among several word sources
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 18,
  parameter int BUSY_TIMEOUT = 4,
  localparam int PTR_W       = $clog2(NUM_REQ)
) (
  input  logic                     txclk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_enable,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     ld_tx_data,
  input  logic                     tx_busy,
  output logic [PTR_W-1:0]         grant_id,
  output logic                     active,
  output logic                     timeout_err,
  input  logic                     clear_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [3:0] TO_LIM = 4'(BUSY_TIMEOUT);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic               ld_q, ld_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] eligible;
  logic [WIDTH-1:0]   words [NUM_REQ];
  logic [PTR_W-1:0]   win_id;
  logic               win_found;
  logic               timeout_hit;

  assign eligible = req_valid & req_enable;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign words[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = PTR_W'(idx);
      end
    end
  end

  // Next-state, handshake and busy-timeout sequencing for one frame at a time.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    ld_d        = 1'b0;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_ready   = '0;
    timeout_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found && !tx_busy) begin
          req_ready[win_id] = 1'b1;
          tx_data_d         = words[win_id];
          grant_d           = win_id;
          ptr_d             = win_id;
          ld_d              = 1'b1;
          state_d           = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == TO_LIM) begin
            // Serializer never acknowledged: drop the word, pointer stays put.
            timeout_hit = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A timeout on the same edge as a clear must leave the flag set.
    if (clear_err) begin
      err_d = 1'b0;
    end
    if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge txclk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      grant_q   <= '0;
      tx_data_q <= '0;
      ld_q      <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      ld_q      <= ld_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign ld_tx_data  = ld_q;
  assign grant_id    = grant_q;
  assign active      = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 18;

  logic                     txclk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_enable;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         tx_data;
  logic                     ld_tx_data;
  logic                     tx_busy;
  logic [1:0]               grant_id;
  logic                     active;
  logic                     timeout_err;
  logic                     clear_err;

  uart_tx_sched #(
    .NUM_REQ(NUM_REQ),
    .WIDTH(WIDTH),
    .BUSY_TIMEOUT(4)
  ) dut (
    .txclk(txclk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_enable(req_enable),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .ld_tx_data(ld_tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .timeout_err(timeout_err),
    .clear_err(clear_err)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  // Minimal uart_tx stand-in: 20-bit frame (start, 18 data LSB first, stop), busy 20 cycles.
  logic        uart_en;
  logic [19:0] sh_q;
  logic [4:0]  left_q;
  logic        tx_out;

  always_ff @(posedge txclk) begin
    if (!reset_n) begin
      sh_q   <= '1;
      left_q <= '0;
    end else if (left_q != 5'd0) begin
      sh_q   <= {1'b1, sh_q[19:1]};
      left_q <= left_q - 5'd1;
    end else if (uart_en && ld_tx_data) begin
      sh_q   <= {1'b1, tx_data, 1'b0};
      left_q <= 5'd20;
    end
  end

  assign tx_busy = (left_q != 5'd0);
  assign tx_out  = tx_busy ? sh_q[0] : 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] d [NUM_REQ];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge txclk);
    #1;
    cyc++;
  endtask

  task automatic wait_ld(input string tag, input int limit);
    int n;
    n = 0;
    while (ld_tx_data !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, ld_tx_data}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (active !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, active}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [19:0] cap;
    logic [19:0] exp_frame;
    int          order [5];
    int          last_cyc;
    logic        any_ld;
    logic        any_rdy;

    d[0] = 18'h2A5A5;
    d[1] = 18'h15A5A;
    d[2] = 18'h3C00F;
    d[3] = 18'h00001;
    req_data   = {d[3], d[2], d[1], d[0]};
    req_valid  = '0;
    req_enable = 4'b1111;
    clear_err  = 1'b0;
    uart_en    = 1'b1;
    reset_n    = 1'b0;
    tick();
    tick();

    // Reset values
    check_eq("rst_active", {31'd0, active}, 32'd0);
    check_eq("rst_ld", {31'd0, ld_tx_data}, 32'd0);
    check_eq("rst_tx_data", {14'd0, tx_data}, 32'd0);
    check_eq("rst_grant", {30'd0, grant_id}, 32'd0);
    check_eq("rst_err", {31'd0, timeout_err}, 32'd0);
    reset_n = 1'b1;

    // Single request on requester 0, serialized frame and active tail
    req_valid = 4'b0001;
    #1;
    check_eq("t1_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = 4'b0000;
    check_eq("t1_ld", {31'd0, ld_tx_data}, 32'd1);
    check_eq("t1_data", {14'd0, tx_data}, 32'h2A5A5);
    check_eq("t1_grant", {30'd0, grant_id}, 32'd0);
    check_eq("t1_ready_after", {28'd0, req_ready}, 32'd0);
    tick();
    check_eq("t1_ld_one_cycle", {31'd0, ld_tx_data}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      cap[i] = tx_out;
      tick();
    end
    exp_frame = {1'b1, 18'h2A5A5, 1'b0};
    check_eq("t1_serial", {12'd0, cap}, {12'd0, exp_frame});
    check_eq("t1_busy_fell", {31'd0, tx_busy}, 32'd0);
    check_eq("t1_active_hold", {31'd0, active}, 32'd1);
    tick();
    check_eq("t1_active_fell", {31'd0, active}, 32'd0);

    // All four valid: round-robin 0,1,2,3,0 at 23-cycle spacing
    do_reset();
    order = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111;
    last_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ld("t2_ld_seen", 40);
      check_eq("t2_grant", {30'd0, grant_id}, order[g]);
      check_eq("t2_data", {14'd0, tx_data}, {14'd0, d[order[g]]});
      if (g > 0) begin
        check_eq("t2_spacing", cyc - last_cyc, 32'd23);
      end
      last_cyc = cyc;
      tick();
    end

    // Mask 1010: only 1 and 3 alternate; widening the mask mid-frame is harmless
    req_enable = 4'b1010;
    order = '{1, 3, 1, 0, 0};
    for (int g = 0; g < 3; g++) begin
      wait_ld("t3_ld_seen", 40);
      check_eq("t3_grant", {30'd0, grant_id}, order[g]);
      tick();
    end
    req_enable = 4'b1111;
    tick();
    check_eq("t3_midframe_grant", {30'd0, grant_id}, 32'd1);
    check_eq("t3_midframe_data", {14'd0, tx_data}, {14'd0, d[1]});
    check_eq("t3_midframe_active", {31'd0, active}, 32'd1);
    wait_ld("t3_ld_next", 40);
    check_eq("t3_next_grant", {30'd0, grant_id}, 32'd2);
    tick();
    req_valid = 4'b0000;
    wait_idle("t3_idle", 40);

    // Serializer disconnected: timeout after 4 cycles in WAIT_BUSY
    uart_en   = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    check_eq("t4_grant", {30'd0, grant_id}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    check_eq("t4_err_early", {31'd0, timeout_err}, 32'd0);
    check_eq("t4_active_early", {31'd0, active}, 32'd1);
    tick();
    check_eq("t4_err_set", {31'd0, timeout_err}, 32'd1);
    check_eq("t4_idle", {31'd0, active}, 32'd0);
    uart_en   = 1'b1;
    req_valid = 4'b1111;
    #1;
    check_eq("t4_ptr_kept", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0000;
    check_eq("t4_regrant", {30'd0, grant_id}, 32'd1);
    check_eq("t4_regrant_ld", {31'd0, ld_tx_data}, 32'd1);
    wait_idle("t4_idle2", 40);
    check_eq("t4_err_sticky", {31'd0, timeout_err}, 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_eq("t4_err_cleared", {31'd0, timeout_err}, 32'd0);

    // clear_err on the same edge as a timeout: set wins
    uart_en   = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_eq("t5_set_wins", {31'd0, timeout_err}, 32'd1);
    tick();
    check_eq("t5_still_set", {31'd0, timeout_err}, 32'd1);

    // Reset during WAIT_DONE after granting requester 2
    uart_en   = 1'b1;
    req_valid = 4'b0100;
    wait_ld("t6_ld_seen", 40);
    check_eq("t6_grant2", {30'd0, grant_id}, 32'd2);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    check_eq("t6_in_frame", {31'd0, active & tx_busy}, 32'd1);
    reset_n = 1'b0;
    tick();
    check_eq("t6_rst_active", {31'd0, active}, 32'd0);
    check_eq("t6_rst_ld", {31'd0, ld_tx_data}, 32'd0);
    check_eq("t6_rst_data", {14'd0, tx_data}, 32'd0);
    check_eq("t6_rst_grant", {30'd0, grant_id}, 32'd0);
    check_eq("t6_rst_err", {31'd0, timeout_err}, 32'd0);
    reset_n = 1'b1;
    #1;
    check_eq("t6_first_ready", {28'd0, req_ready}, 32'h1);
    tick();
    check_eq("t6_first_grant", {30'd0, grant_id}, 32'd0);
    check_eq("t6_first_ld", {31'd0, ld_tx_data}, 32'd1);
    req_valid = 4'b0000;
    wait_idle("t6_idle", 40);

    // All enables low: nothing is ever granted
    req_enable = 4'b0000;
    req_valid  = 4'b1111;
    any_ld  = 1'b0;
    any_rdy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      any_ld  = any_ld | ld_tx_data | active;
      any_rdy = any_rdy | (|req_ready);
    end
    check_eq("t7_no_activity", {31'd0, any_ld}, 32'd0);
    check_eq("t7_no_ready", {31'd0, any_rdy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
